// File: rtl/esc_link_sequencer.sv
// ESC motor-line sequencer: hands the motor pins between the DSHOT engine and the UART
// passthrough bridge, with idle-high guard periods. Define PASSTHRU_TIMEOUT_EN for RX-inactivity exit.
module esc_link_sequencer #(
    parameter logic [15:0] GUARD_CYCLES        = 16'd7200,
    parameter logic [31:0] IDLE_TIMEOUT_CYCLES = 32'd360_000_000
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_mux_sel,
    input  logic       i_dshot_busy,
    input  logic       i_usb_uart_rx,
    output logic       o_dshot_en,
    output logic [1:0] o_route,
    output logic       o_bridge_en,
    output logic [2:0] o_state,
    output logic       o_timeout,
    output logic       o_auto_exit
);

    typedef enum logic [2:0] {
        S_DSHOT     = 3'd0,
        S_DRAIN     = 3'd1,
        S_GUARD_IN  = 3'd2,
        S_PASSTHRU  = 3'd3,
        S_GUARD_OUT = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [15:0] guard_cnt;
    logic        guard_done;
    logic        timeout_hit;
    logic        auto_exit;

    assign guard_done = (guard_cnt == GUARD_CYCLES - 16'd1);

`ifdef PASSTHRU_TIMEOUT_EN
    logic [2:0]  rx_sync;
    logic [31:0] idle_cnt;
    logic        rx_fall;
    logic        timeout_evt;
    logic        timeout_q;
    logic        auto_exit_q;

    // rx_sync[1] is the synchronized line; rx_sync[2] is its previous value for edge detect
    assign rx_fall     = rx_sync[2] & ~rx_sync[1];
    assign timeout_hit = (state == S_PASSTHRU) && (idle_cnt == IDLE_TIMEOUT_CYCLES - 32'd1);
    // a mux request in the same cycle wins, so no timeout is reported then
    assign timeout_evt = timeout_hit && !i_mux_sel;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sync     <= 3'b111;
            idle_cnt    <= 32'd0;
            timeout_q   <= 1'b0;
            auto_exit_q <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[1:0], i_usb_uart_rx};
            timeout_q <= timeout_evt;
            if (state != S_PASSTHRU || rx_fall)
                idle_cnt <= 32'd0;
            else
                idle_cnt <= idle_cnt + 32'd1;
            if (i_mux_sel)
                auto_exit_q <= 1'b0;
            else if (timeout_evt)
                auto_exit_q <= 1'b1;
        end
    end

    assign auto_exit   = auto_exit_q;
    assign o_timeout   = timeout_q;
    assign o_auto_exit = auto_exit_q;
`else
    logic unused_rx;
    assign unused_rx   = i_usb_uart_rx;
    assign timeout_hit = 1'b0;
    assign auto_exit   = 1'b0;
    assign o_timeout   = 1'b0;
    assign o_auto_exit = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_DSHOT;
            guard_cnt <= 16'd0;
        end else begin
            state <= state_next;
            // any state change (including GUARD_IN->GUARD_OUT) restarts the guard count
            if (state_next != state)
                guard_cnt <= 16'd0;
            else if (state == S_GUARD_IN || state == S_GUARD_OUT)
                guard_cnt <= guard_cnt + 16'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_DSHOT:
                if (!i_mux_sel && !auto_exit) state_next = S_DRAIN;
            S_DRAIN:
                if (i_mux_sel)          state_next = S_DSHOT;
                else if (!i_dshot_busy) state_next = S_GUARD_IN;
            S_GUARD_IN:
                if (i_mux_sel)       state_next = S_GUARD_OUT;
                else if (guard_done) state_next = S_PASSTHRU;
            S_PASSTHRU:
                if (i_mux_sel || timeout_hit) state_next = S_GUARD_OUT;
            S_GUARD_OUT:
                if (guard_done) state_next = S_DSHOT;
            default:
                state_next = S_DSHOT;
        endcase
    end

    always_comb begin
        o_dshot_en  = 1'b0;
        o_route     = 2'b00;
        o_bridge_en = 1'b0;
        case (state)
            S_DSHOT: begin
                o_dshot_en = 1'b1;
                o_route    = 2'b01;
            end
            S_DRAIN:    o_route = 2'b01;
            S_PASSTHRU: begin
                o_route     = 2'b10;
                o_bridge_en = 1'b1;
            end
            default:    o_route = 2'b00;
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_esc_link_sequencer.sv
// Scoreboard bench for esc_link_sequencer (GUARD_CYCLES=8, IDLE_TIMEOUT_CYCLES=100).
module tb_esc_link_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mux_sel = 1'b1;
    logic       busy = 1'b0;
    logic       rx = 1'b1;
    logic       dshot_en, bridge_en, timeout, auto_exit;
    logic [1:0] route;
    logic [2:0] state;

    esc_link_sequencer #(
        .GUARD_CYCLES(16'd8),
        .IDLE_TIMEOUT_CYCLES(32'd100)
    ) dut (
        .i_sys_clk(clk),
        .i_rst(rst),
        .i_mux_sel(mux_sel),
        .i_dshot_busy(busy),
        .i_usb_uart_rx(rx),
        .o_dshot_en(dshot_en),
        .o_route(route),
        .o_bridge_en(bridge_en),
        .o_state(state),
        .o_timeout(timeout),
        .o_auto_exit(auto_exit)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [2:0] st;
        logic       to;
        logic       ae;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [1:0] e_route;
    logic       e_en, e_br;

    task automatic chk(input string nm, input logic [2:0] st, input logic to, input logic ae);
        exp_t x;
        x.nm = nm; x.st = st; x.to = to; x.ae = ae;
        q.push_back(x);
    endtask

    task automatic chk_now(input string nm);
        n_vec++;
        if (state !== 3'd0 || route !== 2'b01 || dshot_en !== 1'b1 ||
            bridge_en !== 1'b0 || timeout !== 1'b0 || auto_exit !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got st=%0d route=%b en=%b br=%b to=%b ae=%b, want reset values",
                     nm, state, route, dshot_en, bridge_en, timeout, auto_exit);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter_pt();
        mux_sel = 1'b0;
        busy    = 1'b0;
        step(1); chk("enter_drain", 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1); chk("enter_guard_in", 3'd2, 1'b0, 1'b0);
        end
        step(1); chk("enter_passthru", 3'd3, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the outputs at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e       = q.pop_front();
            e_en    = (e.st == 3'd0);
            e_br    = (e.st == 3'd3);
            e_route = (e.st == 3'd0 || e.st == 3'd1) ? 2'b01 :
                      (e.st == 3'd3) ? 2'b10 : 2'b00;
            n_vec++;
            if (state !== e.st || route !== e_route || dshot_en !== e_en ||
                bridge_en !== e_br || timeout !== e.to || auto_exit !== e.ae) begin
                n_bad++;
                $display("FAIL %s: got st=%0d route=%b en=%b br=%b to=%b ae=%b, want st=%0d route=%b en=%b br=%b to=%b ae=%b",
                         e.nm, state, route, dshot_en, bridge_en, timeout, auto_exit,
                         e.st, e_route, e_en, e_br, e.to, e.ae);
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: wait expired before sequence completed");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1 chk_now("reset_state_direct");
        chk("reset_state", 3'd0, 1'b0, 1'b0);
        step(3);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1); chk("idle_dshot", 3'd0, 1'b0, 1'b0);
        end

        // drain waits on busy, then 8 guard cycles, then passthrough
        mux_sel = 1'b0;
        busy    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1); chk("drain_busy", 3'd1, 1'b0, 1'b0);
        end
        busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1); chk("guard_in", 3'd2, 1'b0, 1'b0);
        end
        step(1); chk("passthru", 3'd3, 1'b0, 1'b0);

        // exit via mux; mux changes inside GUARD_OUT are ignored
        mux_sel = 1'b1;
        step(1); chk("guard_out_first", 3'd4, 1'b0, 1'b0);
        mux_sel = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step(1);
            if (i == 4) mux_sel = 1'b1;
            chk("guard_out_ignore_mux", 3'd4, 1'b0, 1'b0);
        end
        step(1); chk("back_to_dshot", 3'd0, 1'b0, 1'b0);

        // abort during GUARD_IN on its 4th cycle
        mux_sel = 1'b0;
        step(1); chk("abort_drain", 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1); chk("abort_guard_in", 3'd2, 1'b0, 1'b0);
        end
        mux_sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1); chk("abort_guard_out", 3'd4, 1'b0, 1'b0);
        end
        step(1); chk("abort_dshot", 3'd0, 1'b0, 1'b0);

`ifdef PASSTHRU_TIMEOUT_EN
        // falling RX edge every 60 cycles until cycle 500; last fall driven at cycle 480
        enter_pt();
        for (int c = 1; c <= 582; c++) begin
            step(1);
            rx = (c < 500 && c >= 60 && (c % 60) < 30) ? 1'b0 : 1'b1;
            if (c % 50 == 0 || c == 582) chk("pt_active", 3'd3, 1'b0, 1'b0);
        end
        step(1); chk("timeout_exit", 3'd4, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1); chk("timeout_guard_out", 3'd4, 1'b0, 1'b1);
        end
        for (int i = 0; i < 11; i++) begin
            step(1); chk("auto_exit_hold", 3'd0, 1'b0, 1'b1);
        end
        mux_sel = 1'b1;
        step(1); chk("auto_exit_clear", 3'd0, 1'b0, 1'b0);
        mux_sel = 1'b0;
        step(1); chk("reenter_drain", 3'd1, 1'b0, 1'b0);
        mux_sel = 1'b1;
        step(1); chk("drain_abort", 3'd0, 1'b0, 1'b0);
        enter_pt();
`else
        enter_pt();
        for (int c = 1; c <= 1000; c++) begin
            step(1);
            if (c % 100 == 0) chk("pt_no_timeout", 3'd3, 1'b0, 1'b0);
        end
`endif

        // asynchronous reset in the middle of a byte
        rx = 1'b0;
        step(3); chk("pt_midbyte", 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_now("async_reset_direct");
        chk("async_reset", 3'd0, 1'b0, 1'b0);
        step(2); chk("reset_hold", 3'd0, 1'b0, 1'b0);
        rst     = 1'b0;
        mux_sel = 1'b1;
        rx      = 1'b1;
        step(1); chk("post_reset", 3'd0, 1'b0, 1'b0);
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/esc_link_sequencer.md
ESC_LINK_SEQUENCER -- requirements
Module: esc_link_sequencer

Interface
REQ-001 Parameter GUARD_CYCLES, default 7200, number of clocks the motor lines are held driven-high (idle) on every DSHOT/passthrough switch (100 us at 72 MHz); legal range 1 to 65535.
REQ-002 Parameter IDLE_TIMEOUT_CYCLES, default 360_000_000, number of clocks of USB UART RX inactivity that ends passthrough (5 s at 72 MHz); legal range 1 to 2^32-1.
REQ-003 i_sys_clk  input  1  system clock (72 MHz); the block has exactly one clock.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_mux_sel  input  1  Serial/DSHOT mux register bit (0 = passthrough requested, 1 = DSHOT); same clock domain.
REQ-006 i_dshot_busy  input  1  DSHOT controller is mid-frame; same clock domain.
REQ-007 i_usb_uart_rx  input  1  raw USB UART RX line (asynchronous, idle-high).
REQ-008 o_dshot_en  output  1  permission for DSHOT controller to start new frames.
REQ-009 o_route  output  2  motor pin source: 00 driven-high idle, 01 DSHOT, 10 UART bridge, 11 never produced.
REQ-010 o_bridge_en  output  1  enables hardware UART passthrough bridge.
REQ-011 o_state  output  3  current state encoding, for debug probe pins.
REQ-012 o_timeout  output  1  one-cycle pulse when passthrough ends on inactivity.
REQ-013 o_auto_exit  output  1  sticky flag: last passthrough ended on timeout.

Function
REQ-014 The FSM SHALL use states DSHOT=0, DRAIN=1, GUARD_IN=2, PASSTHRU=3, GUARD_OUT=4; o_state equals the state register.
REQ-015 Outputs SHALL be decoded from the state register only: DSHOT -> en=1, route=01, bridge=0; DRAIN -> en=0, route=01, bridge=0; GUARD_IN/GUARD_OUT -> en=0, route=00, bridge=0; PASSTHRU -> en=0, route=10, bridge=1.
REQ-016 DSHOT -> DRAIN when i_mux_sel=0 and o_auto_exit=0; otherwise remain.
REQ-017 DRAIN -> DSHOT when i_mux_sel=1 (abort, priority); else DRAIN -> GUARD_IN when i_dshot_busy=0; else remain.
REQ-018 A 16-bit guard counter SHALL clear on entry to GUARD_IN/GUARD_OUT and increment each cycle in those states; state is exited when counter = GUARD_CYCLES-1, giving exactly GUARD_CYCLES cycles in the state.
REQ-019 GUARD_IN -> GUARD_OUT immediately (counter restarted) when i_mux_sel=1; else -> PASSTHRU on guard expiry.
REQ-020 PASSTHRU -> GUARD_OUT when i_mux_sel=1, or on inactivity timeout (REQ-023); simultaneous events count as mux exit (no o_timeout pulse).
REQ-021 GUARD_OUT -> DSHOT on guard expiry regardless of i_mux_sel; i_mux_sel changes during GUARD_OUT are ignored.
REQ-022 i_usb_uart_rx SHALL pass a 2-flop synchronizer reset to 1; activity = falling edge of synchronized signal.
REQ-023 A 32-bit idle counter SHALL clear on PASSTHRU entry and on each activity edge, increment otherwise in PASSTHRU, and signal timeout when it reaches IDLE_TIMEOUT_CYCLES-1.
REQ-024 On timeout exit o_timeout SHALL pulse high for the one cycle of the PASSTHRU->GUARD_OUT transition (registered, visible the following cycle) and o_auto_exit SHALL set.
REQ-025 o_auto_exit SHALL clear on any cycle with i_mux_sel=1; it blocks re-entry so passthrough requires a fresh 1->0 of i_mux_sel.
REQ-026 Minimum DSHOT->PASSTHRU latency with i_dshot_busy=0: 1 (DRAIN) + 1 + GUARD_CYCLES cycles after i_mux_sel falls.

Reset
REQ-027 On i_rst=1 (asynchronous assert, synchronous-to-clock release) state SHALL be DSHOT, counters 0, synchronizer flops 1, o_timeout=0, o_auto_exit=0, hence o_dshot_en=1, o_route=01, o_bridge_en=0, o_state=0.
REQ-028 Reset mid-passthrough SHALL return directly to DSHOT outputs with no guard period.

Configuration
REQ-029 Macro PASSTHRU_TIMEOUT_EN defined: idle counter, o_timeout and o_auto_exit behave per REQ-023..025.
REQ-030 Macro PASSTHRU_TIMEOUT_EN undefined: no idle counter or synchronizer synthesized, PASSTHRU exits only on i_mux_sel=1, o_timeout and o_auto_exit tied 0.

Verification (GUARD_CYCLES=8, IDLE_TIMEOUT_CYCLES=100)
REQ-031 Reset release, i_mux_sel=1 -> o_state=0, o_route=01, o_dshot_en=1 held 50 cycles.
REQ-032 i_dshot_busy=1, i_mux_sel 1->0, busy falls 20 cycles later -> DRAIN for 20 cycles with route=01, then route=00 exactly 8 cycles, then route=10 and o_bridge_en=1.
REQ-033 i_mux_sel=1 on 4th GUARD_IN cycle -> GUARD_OUT 8 cycles, then DSHOT; bridge never enabled.
REQ-034 In PASSTHRU, RX toggles every 60 cycles for 500 cycles then idles high -> no exit while toggling; exit 100 cycles after last falling edge (+2 sync), one o_timeout pulse, o_auto_exit=1, state DSHOT after 8 guard cycles and remains there while i_mux_sel=0; i_mux_sel pulse 1 then 0 re-enters DRAIN.
REQ-035 i_rst pulsed in PASSTHRU mid-byte -> outputs equal REQ-027 values asynchronously, before next clock edge.
REQ-036 Build without PASSTHRU_TIMEOUT_EN, RX idle 1000 cycles in PASSTHRU -> remains PASSTHRU, o_timeout=0.
